// File: rtl/axi_sram_slave.sv
// AXI slave backed by an inferred synchronous RAM: one outstanding burst on a
// shared read/write address channel, INCR/FIXED bursts up to 256 beats.
module axi_sram_slave #(
    parameter int          WIDTH     = 32,
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic               axi_clk,
    input  logic               rstn,
    input  logic [7:0]         aid,
    input  logic [31:0]        aaddr,
    input  logic [7:0]         alen,
    input  logic [2:0]         asize,
    input  logic [1:0]         aburst,
    input  logic [1:0]         alock,
    input  logic               atype,
    input  logic               avalid,
    output logic               aready,
    input  logic [7:0]         wid,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [WIDTH/8-1:0] wstrb,
    input  logic               wlast,
    input  logic               wvalid,
    output logic               wready,
    output logic [7:0]         bid,
    output logic [1:0]         bresp,
    output logic               bvalid,
    input  logic               bready,
    output logic [7:0]         rid,
    output logic [WIDTH-1:0]   rdata,
    output logic [1:0]         rresp,
    output logic               rlast,
    output logic               rvalid,
    input  logic               rready,
    output logic               err
);
    localparam int BYTES = WIDTH / 8;
    localparam int LOG2B = $clog2(BYTES);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, RD_FETCH, RD_DATA} state_t;
    state_t state_reg, state_next;

    logic [WIDTH-1:0]  mem [0:DEPTH-1];
    logic [ADDR_W-1:0] idx_reg;
    logic [ADDR_W-1:0] idx_adv;
    logic [7:0]        id_reg;
    logic [7:0]        len_reg;
    logic              fixed_reg;
    logic [8:0]        beat_reg;
    logic [WIDTH-1:0]  rdata_reg;
    logic              err_reg;
    logic              live_reg;

    logic [31:0] offset;
    logic        range_err;
    logic        a_err;
    logic        beat_last;
    logic        a_hs;
    logic        w_hs;
    logic        r_hs;

    logic unused_ok;
    assign unused_ok = &{1'b0, alock, wid};

    assign offset    = aaddr - BASE_ADDR;
    // Any offset bit above the RAM's byte span means the address fell outside the window.
    assign range_err = (offset >> (ADDR_W + LOG2B)) != 32'd0;
    assign a_err     = aburst[1] | (asize != 3'(LOG2B)) | range_err;
    assign beat_last = (beat_reg == {1'b0, len_reg});
    assign idx_adv   = fixed_reg ? idx_reg : idx_reg + 1'b1;

    assign a_hs = avalid && live_reg && (state_reg == IDLE);
    assign w_hs = wvalid && (state_reg == WRITE);
    assign r_hs = rready && (state_reg == RD_DATA);

    always_ff @(posedge axi_clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        aready     = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;
        rvalid     = 1'b0;
        rlast      = 1'b0;
        case (state_reg)
            IDLE: begin
                aready = live_reg;
                if (a_hs) state_next = atype ? WRITE : RD_FETCH;
            end
            WRITE: begin
                wready = 1'b1;
                if (w_hs && beat_last) state_next = WRESP;
            end
            WRESP: begin
                bvalid = 1'b1;
                if (bready) state_next = IDLE;
            end
            RD_FETCH: state_next = RD_DATA;
            RD_DATA: begin
                rvalid = 1'b1;
                rlast  = beat_last;
                if (r_hs && beat_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // live_reg keeps aready low during the reset cycle itself.
    always_ff @(posedge axi_clk or negedge rstn) begin
        if (!rstn) begin
            live_reg  <= 1'b0;
            id_reg    <= 8'd0;
            len_reg   <= 8'd0;
            fixed_reg <= 1'b0;
            idx_reg   <= '0;
            beat_reg  <= 9'd0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            live_reg <= 1'b1;
            if (a_hs) begin
                id_reg    <= aid;
                len_reg   <= alen;
                fixed_reg <= (aburst == 2'b00);
                idx_reg   <= offset[LOG2B +: ADDR_W];
                beat_reg  <= 9'd0;
                if (a_err) err_reg <= 1'b1;
            end
            if (w_hs) begin
                if (wlast != beat_last) err_reg <= 1'b1;
                if (beat_last) begin
                    beat_reg <= 9'd0;
                end else begin
                    beat_reg <= beat_reg + 9'd1;
                    idx_reg  <= idx_adv;
                end
            end
            if (state_reg == RD_FETCH) rdata_reg <= mem[idx_reg];
            // Fetch the next word on the accepting edge so rvalid never drops mid-burst.
            if (r_hs) begin
                if (beat_last) begin
                    beat_reg <= 9'd0;
                end else begin
                    beat_reg  <= beat_reg + 9'd1;
                    idx_reg   <= idx_adv;
                    rdata_reg <= mem[idx_adv];
                end
            end
        end
    end

    always_ff @(posedge axi_clk) begin
        if (w_hs) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wstrb[b]) mem[idx_reg][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign bid   = id_reg;
    assign rid   = id_reg;
    assign rdata = rdata_reg;
    assign bresp = 2'b00;
    assign rresp = 2'b00;
    assign err   = err_reg;
endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

On-chip AXI slave memory that terminates the memory-checker traffic generator's combined read/write address channel. It accepts single-ID INCR and FIXED bursts of up to 256 beats and stores write data in an inferred synchronous RAM. It returns write responses and read data with full-throughput read beats. It serves as the bring-up target for the DDR test path, so the traffic generator can be exercised without the DDR controller.

## Interface
- WIDTH, 32, data width in bits (32/64/128/256)
- ADDR_W, 10, RAM depth in words (2^ADDR_W)
- BASE_ADDR, 32'h00000000, byte address mapped to word 0
- axi_clk  in  1  sole clock
- rstn  in  1  asynchronous active-low reset
- aid  in  8  transaction ID
- aaddr  in  32  byte start address
- alen  in  8  beats minus one
- asize  in  3  bytes per beat, log2
- aburst  in  2  00 FIXED, 01 INCR, 1x unsupported
- alock  in  2  ignored
- atype  in  1  1 write, 0 read
- avalid  in  1  address valid
- aready  out  1  address ready
- wid  in  8  ignored
- wdata  in  WIDTH  write data
- wstrb  in  WIDTH/8  byte enables
- wlast  in  1  last write beat
- wvalid  in  1  write valid
- wready  out  1  write ready
- bid  out  8  response ID
- bresp  out  2  always 2'b00
- bvalid  out  1  response valid
- bready  in  1  response ready
- rid  out  8  read ID
- rdata  out  WIDTH  read data
- rresp  out  2  always 2'b00
- rlast  out  1  last read beat
- rvalid  out  1  read valid
- rready  in  1  read ready
- err  out  1  sticky protocol-error flag

## Operation
- States:
  - IDLE: aready=1. On avalid&aready, latch aid, alen, aburst, and word index = (aaddr-BASE_ADDR)>>log2(WIDTH/8) truncated to ADDR_W bits. Go to WRITE if atype=1, else to RD_FETCH.
  - WRITE: wready=1. Each wvalid&wready writes the bytes enabled by wstrb at the current index and increments the beat counter. On beat alen go to WRESP.
  - WRESP: bvalid=1 and bid=latched aid. On bready go to IDLE.
  - RD_FETCH: one cycle. The RAM reads the current index. Go to RD_DATA.
  - RD_DATA: rvalid=1, rid=latched aid, rlast=1 on beat alen. On rvalid&rready:
    - if last, go to IDLE;
    - otherwise advance the index and read the next word in the same cycle, so rvalid stays high.
- Index advance: INCR adds 1 modulo 2^ADDR_W, so the address wraps silently at the top of the RAM. FIXED keeps the index unchanged.
- Only one transaction is outstanding. aready=0 outside IDLE. No new address is accepted until the B handshake or the final R handshake completes.
- err is set and held until reset by any of:
  - aburst=1x (the burst is then treated as INCR);
  - asize not equal to log2(WIDTH/8) (the burst still uses word stepping);
  - wlast not matching the internal last-beat count on any accepted beat;
  - an address outside BASE_ADDR..BASE_ADDR+2^ADDR_W*WIDTH/8-1 (the address is still truncated and served).
- The beat counter is 9 bits wide, to cover alen=255 (256 beats).

## Timing
- Reset values: aready=0 in the reset cycle, then 1 in IDLE. wready, bvalid, rvalid, rlast, and err are 0. bid, rid, and rdata are 0. bresp and rresp are 0. RAM contents are not reset.
- aready is a decode of the state register, with no combinational path from avalid.
- Write path:
  - wready rises the cycle after the address handshake.
  - bvalid rises the cycle after the last W handshake.
- Read path:
  - rvalid for the first beat rises 2 cycles after the address handshake.
  - Subsequent beats are back-to-back while rready=1.
  - rdata, rlast, and rid hold stable while rvalid=1 and rready=0.
- Write-to-read ordering: a read issued after the B handshake of a write to the same address returns the new data.
- Reset asserted mid-burst: all outputs return to their reset values immediately. The state machine returns to IDLE and the partial burst is discarded. Words already written stay in the RAM.

## Test plan
- Write then read back, INCR, alen=69, WIDTH=32, addr 0x0 → 70 beats stored. bvalid comes 1 cycle after the last beat with bid equal to aid. The read returns identical data, rlast on beat 70, err=0.
- Read with rready toggled randomly, alen=15 → 16 beats. Data is stable under stall, with no dropped or duplicated beat. With rready held at 1, beats come one per cycle.
- wstrb=4'b0101 over a word pre-written with 0xFFFFFFFF, data 0x00000000 → read returns 0xFF00FF00.
- INCR burst starting at word 2^ADDR_W-2, alen=3 → the writes land at the last two words, then at words 0 and 1. The read over the same range matches.
- FIXED burst, alen=3 → only the last beat's data remains at the target word. Any wlast asserted on beat 2 sets err=1, which stays set until reset.
- Reset pulse during beat 10 of a 70-beat write → wready and bvalid are 0 immediately and the block is in IDLE with aready=1. A new write then completes normally.
